// File: rtl/bsg_counter_set_up_limit_pkg.sv
// Shared types for the set/count-up limit counter: FSM state encoding and datapath select.
// The optional abort feature is enabled with BSG_COUNTER_SET_UP_LIMIT_ABORT_EN.
package bsg_counter_set_up_limit_pkg;

  localparam int state_width_lp = 2;

  typedef enum logic [state_width_lp-1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_LOAD  = 2'b01,
    SEL_INC   = 2'b10,
    SEL_CLEAR = 2'b11
  } count_sel_e;

endpackage

// File: rtl/bsg_counter_set_up_limit_if.sv
// Load (ready/valid) and completion (valid/yumi) ports of the limit counter.
// abort_i exists only when BSG_COUNTER_SET_UP_LIMIT_ABORT_EN is defined.
interface bsg_counter_set_up_limit_if #(
  parameter int width_p = 32
);

  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] val_i;
  logic [width_p-1:0] limit_i;
  logic               up_i;
  logic [width_p-1:0] count_r_o;
  logic               v_o;
  logic               yumi_i;
`ifdef BSG_COUNTER_SET_UP_LIMIT_ABORT_EN
  logic               abort_i;
`endif

`ifdef BSG_COUNTER_SET_UP_LIMIT_ABORT_EN
  modport master (
    output v_i, val_i, limit_i, up_i, yumi_i, abort_i,
    input  ready_o, count_r_o, v_o
  );

  modport slave (
    input  v_i, val_i, limit_i, up_i, yumi_i, abort_i,
    output ready_o, count_r_o, v_o
  );
`else
  modport master (
    output v_i, val_i, limit_i, up_i, yumi_i,
    input  ready_o, count_r_o, v_o
  );

  modport slave (
    input  v_i, val_i, limit_i, up_i, yumi_i,
    output ready_o, count_r_o, v_o
  );
`endif

endinterface

// File: rtl/bsg_counter_set_up_limit_fsm.sv
// Control FSM: state register, ready/valid decode and count/limit select strobes.
// Honours abort_i only when BSG_COUNTER_SET_UP_LIMIT_ABORT_EN is defined.
module bsg_counter_set_up_limit_fsm
  import bsg_counter_set_up_limit_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       v_i,
  input  logic       up_i,
  input  logic       yumi_i,
`ifdef BSG_COUNTER_SET_UP_LIMIT_ABORT_EN
  input  logic       abort_i,
`endif
  input  logic       load_done_i,
  input  logic       inc_done_i,
  output logic       ready_o,
  output logic       v_o,
  output count_sel_e count_sel_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ready_o/v_o depend on state_q alone, so there is no input-to-output path.
  always_comb begin
    state_d     = state_q;
    count_sel_o = SEL_HOLD;
    ready_o     = 1'b0;
    v_o         = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          count_sel_o = SEL_LOAD;
          state_d     = load_done_i ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (up_i) begin
          count_sel_o = SEL_INC;
          if (inc_done_i) state_d = DONE;
        end
      end
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef BSG_COUNTER_SET_UP_LIMIT_ABORT_EN
    if (abort_i && (state_q == COUNT || state_q == DONE)) begin
      state_d     = IDLE;
      count_sel_o = SEL_CLEAR;
    end
`endif
  end

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: rtl/bsg_counter_set_up_limit.sv
// Loadable up-counter with programmable terminal limit; completion held until yumi_i.
// Define BSG_COUNTER_SET_UP_LIMIT_ABORT_EN to add the abort_i port.
module bsg_counter_set_up_limit
  import bsg_counter_set_up_limit_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bsg_counter_set_up_limit_if.slave     io
);

  logic [width_p-1:0] count_q, count_d;
  logic [width_p-1:0] limit_q, limit_d;
  logic [width_p-1:0] count_inc;
  logic               load_done;
  logic               inc_done;
  count_sel_e         count_sel;

  // The FSM stops incrementing once count == limit, so count_inc never wraps in use.
  assign count_inc = count_q + width_p'(1);
  assign load_done = (io.val_i >= io.limit_i);
  assign inc_done  = (count_inc == limit_q);

  bsg_counter_set_up_limit_fsm u_fsm (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (io.v_i),
    .up_i        (io.up_i),
    .yumi_i      (io.yumi_i),
`ifdef BSG_COUNTER_SET_UP_LIMIT_ABORT_EN
    .abort_i     (io.abort_i),
`endif
    .load_done_i (load_done),
    .inc_done_i  (inc_done),
    .ready_o     (io.ready_o),
    .v_o         (io.v_o),
    .count_sel_o (count_sel)
  );

  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    case (count_sel)
      SEL_LOAD: begin
        count_d = io.val_i;
        limit_d = io.limit_i;
      end
      SEL_INC:   count_d = count_inc;
      SEL_CLEAR: count_d = '0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign io.count_r_o = count_q;

endmodule

// File: doc/bsg_counter_set_up_limit.md
# bsg_counter_set_up_limit

Loadable up-counter with a programmable terminal limit and a ready/valid load port plus a valid/yumi completion port. It is the counting-up counterpart to the set/count-down timer. A producer loads a start value and a limit, and events on `up_i` advance the count. When the count reaches the limit, a completion token is raised and held until the consumer takes it. Typical uses are credit-return accumulation, event-count thresholds and packet-length tracking.

## Interface
- `width_p`, default 32: counter, start-value and limit width in bits.
- `clk_i`  in  1  sole clock; rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `v_i`  in  1  load request; valid with `val_i`/`limit_i`.
- `ready_o`  out  1  load accepted when `v_i & ready_o` at a clock edge.
- `val_i`  in  `width_p`  start count.
- `limit_i`  in  `width_p`  terminal count, unsigned.
- `up_i`  in  1  increment-by-one event; honoured only in COUNT.
- `count_r_o`  out  `width_p`  registered current count.
- `v_o`  out  1  completion valid; count reached the limit.
- `yumi_i`  in  1  consumer takes completion; legal only when `v_o=1`.
- `abort_i`  in  1  present only with `BSG_COUNTER_SET_UP_LIMIT_ABORT_EN`.

## Operation
- **States:** IDLE, COUNT, DONE. Encoded in a 2-bit state register; the fourth encoding recovers to IDLE.
- **Reset (async):** state=IDLE, `count_r_o`=0, internal `limit_r`=0.
  - Outputs during reset: `ready_o`=1, `v_o`=0.
- **IDLE:**
  - `ready_o`=1, `v_o`=0, count holds.
  - On `v_i`: `count_r_o`<=`val_i` and `limit_r`<=`limit_i`.
  - Next state is DONE if `val_i >= limit_i` (unsigned), else COUNT.
- **COUNT:**
  - `ready_o`=0, `v_o`=0.
  - `up_i`=1: count<=count+1. If count+1 == `limit_r`, next state is DONE.
  - `up_i`=0: hold.
  - The count never exceeds `limit_r`, so no wrap is possible.
- **DONE:**
  - `v_o`=1, `ready_o`=0.
  - Count holds at the terminal value; `up_i` is ignored.
  - `yumi_i`: next state is IDLE; count still holds until the next load.
- **Ignored inputs:**
  - `v_i` is ignored outside IDLE, since `ready_o`=0 there.
  - `yumi_i` without `v_o` is a protocol error: assertion in simulation; RTL ignores it.
- **Arithmetic:** unsigned compare and increment only, all at `width_p` bits; no carry-out is produced.
- **Boundaries:**
  - `val_i == limit_i`, including both 0: straight to DONE with no `up_i` needed.
  - `val_i > limit_i`: straight to DONE; count = `val_i`, unchanged.
  - `limit_i` = 2^`width_p`−1 is legal; increments stop exactly at all-ones.

## Timing
- Load accepted at edge t:
  - `count_r_o` = `val_i` from t+1.
  - `v_o`=1 from t+1 if `val_i >= limit_i`.
- Final `up_i` sampled at edge t: `count_r_o` = limit and `v_o`=1 together from t+1. Latency is 1 cycle.
- `yumi_i` at edge t: `v_o`=0 and `ready_o`=1 from t+1. Earliest next load is at edge t+1.
- All outputs are driven from registers or from state decode only, with no combinational input-to-output paths.
- Reset mid-operation: outputs take their reset values immediately on assertion, asynchronously. Normal behaviour resumes on the first edge after deassertion.

## Configuration
- `BSG_COUNTER_SET_UP_LIMIT_ABORT_EN` defined:
  - Adds `abort_i`.
  - In COUNT or DONE, `abort_i` at edge t gives state=IDLE and `count_r_o`=0 from t+1. No completion is issued.
  - `abort_i` wins over a simultaneous `up_i` or `yumi_i`. It has no effect in IDLE.
- Undefined: the `abort_i` port does not exist, and the only exits from COUNT/DONE are limit-reached and `yumi_i`.

## Structure
- **Package** `bsg_counter_set_up_limit_pkg`:
  - State enum typedef with IDLE=2'b00, COUNT=2'b01, DONE=2'b10.
  - State-width constant.
- **Sub-module** `bsg_counter_set_up_limit_fsm`: holds the state register, `ready_o`/`v_o` decode, and load/increment/hold/clear select strobes.
- **Top level:** keeps the count and limit registers and the comparator/incrementer datapath.

## Test plan
- **Reset:** assert `reset_i` mid-COUNT with count=7 → immediately `count_r_o`=0, `v_o`=0, `ready_o`=1.
- **Normal count:** load val=3, limit=6; pulse `up_i` 3 times on non-consecutive cycles.
  - Expect `count_r_o` 3→4→5→6.
  - Expect `v_o`=1 the cycle `count_r_o`=6.
  - Extra `up_i` leaves 6.
- **Immediate done:** load val=9, limit=5 → next cycle `count_r_o`=9, `v_o`=1; `yumi_i` → `ready_o`=1 the following cycle.
- **Width extreme:** `width_p`=32, load val=32'hFFFF_FFFE, limit=32'hFFFF_FFFF; one `up_i` → count=32'hFFFF_FFFF, `v_o`=1, no wrap.
- **Back-to-back handshake:**
  - `v_i` held high through COUNT/DONE → no reload until IDLE.
  - `yumi_i` at t → a new load (val=0, limit=0) accepted at t+1 and `v_o`=1 again at t+2.
- **Abort (macro on):** load val=0, limit=10; 4 `up_i` then `abort_i` together with `up_i` → `count_r_o`=0, state IDLE, `v_o` never asserted.
